// File: rtl/ps2_operand_entry.sv
// PS/2 scan code set 2 keystroke decoder feeding the ALU operand registers.
// Handles F0/E0 prefixes, typematic suppression and the A/op/B/Enter flow.
module ps2_operand_entry #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          code,
    input  logic                code_valid,
    output logic [4*DIGITS-1:0] entry,
    output logic [4*DIGITS-1:0] operand_a,
    output logic [4*DIGITS-1:0] operand_b,
    output logic [1:0]          opcode,
    output logic                go,
    output logic                err,
    output logic [1:0]          state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        DONE    = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic           brk_q, brk_d;
    logic           ext_q, ext_d;
    logic [7:0]     held_code_q, held_code_d;
    logic           held_ext_q, held_ext_d;
    logic           held_vld_q, held_vld_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   entry_q, entry_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [1:0]     opc_q, opc_d;
    logic           go_q, go_d;
    logic           err_q, err_d;

    logic           dig_hit;
    logic [3:0]     dig_val;
    logic           op_hit;
    logic [1:0]     op_val;
    logic           enter_hit;
    logic           bs_hit;
    logic           esc_hit;
    logic           held_match;

    assign held_match = held_vld_q && held_code_q == code &&
                        held_ext_q == ext_q;

    always_comb begin
        dig_hit = 1'b1;
        dig_val = 4'd0;
        unique case (code)
            8'h45, 8'h70: dig_val = 4'd0;
            8'h16, 8'h69: dig_val = 4'd1;
            8'h1E, 8'h72: dig_val = 4'd2;
            8'h26, 8'h7A: dig_val = 4'd3;
            8'h25, 8'h6B: dig_val = 4'd4;
            8'h2E, 8'h73: dig_val = 4'd5;
            8'h36, 8'h74: dig_val = 4'd6;
            8'h3D, 8'h6C: dig_val = 4'd7;
            8'h3E, 8'h75: dig_val = 4'd8;
            8'h46, 8'h7D: dig_val = 4'd9;
            default:      dig_hit = 1'b0;
        endcase
        if (ext_q) dig_hit = 1'b0;
    end

    always_comb begin
        op_hit    = 1'b0;
        op_val    = 2'b00;
        enter_hit = 1'b0;
        bs_hit    = 1'b0;
        esc_hit   = 1'b0;
        if (ext_q) begin
            op_hit    = code == 8'h4A;
            op_val    = 2'b11;
            enter_hit = code == 8'h5A;
        end else begin
            unique case (code)
                8'h79:   op_hit = 1'b1;
                8'h7B:   begin op_hit = 1'b1; op_val = 2'b01; end
                8'h7C:   begin op_hit = 1'b1; op_val = 2'b10; end
                8'h5A:   enter_hit = 1'b1;
                8'h66:   bs_hit = 1'b1;
                8'h76:   esc_hit = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        held_vld_d  = held_vld_q;
        cnt_d       = cnt_q;
        entry_d     = entry_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opc_d       = opc_q;
        go_d        = 1'b0;
        err_d       = 1'b0;
        if (code_valid) begin
            if (code == 8'hF0) begin
                brk_d = 1'b1;
            end else if (code == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (brk_q) begin
                    if (held_match) held_vld_d = 1'b0;
                end else if (!held_match) begin
                    held_code_d = code;
                    held_ext_d  = ext_q;
                    held_vld_d  = 1'b1;
                    unique case (1'b1)
                        esc_hit: begin
                            state_d     = ENTER_A;
                            held_code_d = '0;
                            held_ext_d  = 1'b0;
                            held_vld_d  = 1'b0;
                            cnt_d       = '0;
                            entry_d     = '0;
                            opa_d       = '0;
                            opb_d       = '0;
                            opc_d       = 2'b00;
                        end
                        dig_hit: begin
                            if (state_q == DONE) begin
                                opa_d   = '0;
                                opb_d   = '0;
                                entry_d = W'(dig_val);
                                cnt_d   = CW'(1);
                                state_d = ENTER_A;
                            end else if (cnt_q < CW'(DIGITS)) begin
                                entry_d = (entry_q << 4) | W'(dig_val);
                                cnt_d   = cnt_q + CW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        bs_hit: begin
                            if (state_q != DONE && cnt_q != '0) begin
                                entry_d = entry_q >> 4;
                                cnt_d   = cnt_q - CW'(1);
                            end
                        end
                        op_hit: begin
                            if (state_q == ENTER_A) begin
                                opa_d   = entry_q;
                                opc_d   = op_val;
                                entry_d = '0;
                                cnt_d   = '0;
                                state_d = ENTER_B;
                            end else if (state_q == ENTER_B &&
                                         cnt_q == '0) begin
                                opc_d = op_val;
                            end
                        end
                        enter_hit: begin
                            // Enter only commits once operand A is latched
                            if (state_q == ENTER_B) begin
                                opb_d   = entry_q;
                                go_d    = 1'b1;
                                entry_d = '0;
                                cnt_d   = '0;
                                state_d = DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ENTER_A;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            held_code_q <= '0;
            held_ext_q  <= 1'b0;
            held_vld_q  <= 1'b0;
            cnt_q       <= '0;
            entry_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= 2'b00;
            go_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            held_vld_q  <= held_vld_d;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
            go_q        <= go_d;
            err_q       <= err_d;
        end
    end

    assign entry     = entry_q;
    assign operand_a = opa_q;
    assign operand_b = opb_q;
    assign opcode    = opc_q;
    assign go        = go_q;
    assign err       = err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ps2_operand_entry.sv
// Scoreboard bench for ps2_operand_entry: go/err events are queued when the
// triggering key is driven and matched when the pulse appears.
module tb_ps2_operand_entry;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   code = 8'h00;
    logic         code_valid = 1'b0;
    logic [W-1:0] entry, operand_a, operand_b;
    logic [1:0]   opcode, state;
    logic         go, err;

    typedef struct {
        int         kind;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0] op;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_go = 1'b0;
    logic prev_err = 1'b0;

    ps2_operand_entry #(.DIGITS(DIGITS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .code(code),
        .code_valid(code_valid),
        .entry(entry),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .opcode(opcode),
        .go(go),
        .err(err),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        code = c;
        code_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        code_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_go(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op);
        exp_t e;
        e.kind = 0; e.a = a; e.b = b; e.op = op;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.kind = 1; e.a = '0; e.b = '0; e.op = 2'b00;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (go === 1'b1) begin
            check("go_width", {31'd0, prev_go}, 0);
            if (sb.size() == 0) begin
                check("go_spurious", 1, 0);
            end else begin
                e = sb.pop_front();
                check("go_kind", 0, e.kind);
                check("go_operand_a", operand_a, e.a);
                check("go_operand_b", operand_b, e.b);
                check("go_opcode", opcode, e.op);
                check("go_state", state, 2);
            end
        end
        if (err === 1'b1) begin
            check("err_width", {31'd0, prev_err}, 0);
            if (sb.size() == 0) begin
                check("err_spurious", 1, 0);
            end else begin
                e = sb.pop_front();
                check("err_kind", 1, e.kind);
            end
        end
        prev_go = go;
        prev_err = err;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_entry", entry, 0);
        check("rst_operand_a", operand_a, 0);
        check("rst_operand_b", operand_b, 0);
        check("rst_opcode", opcode, 0);
        check("rst_state", state, 0);
        check("rst_go", go, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic add, back-to-back strobes
        send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        send(8'h79); send(8'hF0); send(8'h79);
        send(8'h25); send(8'hF0); send(8'h25);
        push_go(16'h0012, 16'h0004, 2'b00);
        send(8'h5A);
        check("t1_go_now", go, 1);
        check("t1_state", state, 2);
        send(8'hF0); send(8'h5A);
        idle(2);
        check("t1_go_low", go, 0);
        check("t1_hold_b", operand_b, 16'h0004);
        send(8'h26);
        idle(1);
        check("done_dig_state", state, 0);
        check("done_dig_entry", entry, 3);
        check("done_dig_a", operand_a, 0);
        check("done_dig_b", operand_b, 0);

        // typematic
        send(8'h76);
        send(8'h16); send(8'h16); send(8'h16);
        send(8'hF0); send(8'h16); send(8'h16);
        idle(1);
        check("typematic_entry", entry, 16'h0011);

        // overflow
        send(8'h76);
        send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        send(8'h26); send(8'hF0); send(8'h26);
        send(8'h25); send(8'hF0); send(8'h25);
        push_err();
        send(8'h2E);
        check("ovf_err_now", err, 1);
        send(8'hF0); send(8'h2E);
        idle(1);
        check("ovf_entry", entry, 16'h1234);
        send(8'h66); send(8'h36);
        idle(1);
        check("ovf_cnt_entry", entry, 16'h1236);

        // extended keys
        send(8'h76);
        send(8'h69); send(8'hE0); send(8'h4A);
        idle(1);
        check("ext_operand_a", operand_a, 1);
        check("ext_opcode", opcode, 3);
        check("ext_state_b", state, 1);
        send(8'hE0); send(8'h70);
        idle(1);
        check("ext_e070_ignored", entry, 0);
        send(8'h72);
        idle(1);
        check("ext_entry", entry, 2);
        push_go(16'h0001, 16'h0002, 2'b11);
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'hF0); send(8'h5A);
        idle(1);
        check("ext_state_done", state, 2);

        // edits
        send(8'h76);
        send(8'h16); send(8'h1E); send(8'h66);
        idle(1);
        check("bs_entry", entry, 1);
        send(8'h79);
        idle(1);
        check("edit_operand_a", operand_a, 1);
        check("edit_state", state, 1);
        send(8'h7B);
        idle(1);
        check("edit_op_replace", opcode, 1);
        send(8'h16); send(8'h7C);
        idle(1);
        check("edit_op_kept", opcode, 1);
        send(8'h76);
        idle(1);
        check("esc_entry", entry, 0);
        check("esc_operand_a", operand_a, 0);
        check("esc_opcode", opcode, 0);
        check("esc_state", state, 0);

        // reset discards a pending break prefix
        send(8'hF0);
        idle(1);
        rst_n = 1'b0;
        code = 8'h16;
        code_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        code_valid = 1'b0;
        check("rst_wins", entry, 0);
        send(8'h16);
        idle(1);
        check("rst_fresh_make", entry, 1);

        idle(4);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_operand_entry.md
# ps2_operand_entry

Keystroke-to-operand front end for the ALU. Consumes the scancode byte stream from the PS/2 receiver: one byte per `code_valid` strobe, scan code set 2. It tracks break (F0) and extended (E0) prefixes, suppresses typematic repeats and assembles two BCD operands plus an opcode. It issues a one-cycle `go` to the ALU when Enter is pressed, and exports the live entry digits and the entry state for the seven-segment display stage.

## Interface
- `DIGITS`, 4: BCD digits per operand (1..8)
- `clk` in 1: system clock; all logic rises on posedge
- `rst_n` in 1: reset, synchronous and active-low; one clock, sync active-low reset
- `code` in 8: scancode byte from the PS/2 receiver
- `code_valid` in 1: one-cycle strobe, `code` valid; may be asserted on consecutive cycles
- `entry` out 4*DIGITS: digits currently being typed, BCD, least-significant digit in [3:0]
- `operand_a` out 4*DIGITS: latched first operand, BCD
- `operand_b` out 4*DIGITS: latched second operand, BCD
- `opcode` out 2: 00 add, 01 sub, 10 mul, 11 div
- `go` out 1: one-cycle pulse, operands and opcode valid
- `err` out 1: one-cycle pulse, digit rejected because entry is full
- `state` out 2: 00 ENTER_A, 01 ENTER_B, 10 DONE

## Operation
- Prefix handling:
  - F0 sets `brk`; E0 sets `ext`.
  - The next non-prefix byte is the key event; `brk` and `ext` both clear after it.
  - An event with `brk` set is a release. A release never edits data; it only clears the held key when the code matches.
- Typematic suppression:
  - Register `held` = {`ext`, code, valid} of the last accepted make.
  - A make equal to `held` while valid is ignored.
  - Any other make is accepted and replaces `held`.
- Key map, make events only:
  - Digits 0–9, `ext`=0: top row 45,16,1E,26,25,2E,36,3D,3E,46; keypad 70,69,72,7A,6B,73,74,6C,75,7D.
  - Operators: 79 add, 7B sub, 7C mul (`ext`=0); E0 4A div.
  - Enter: 5A or E0 5A. Backspace: 66. Esc: 76.
  - Every other code, including any other E0-prefixed key (e.g. E0 70), is ignored.
- `cnt` = digits in `entry`, 0..DIGITS.
- Digit:
  - If `cnt`<DIGITS: `entry` <= {`entry` shifted left 4, d}, `cnt`++.
  - Else: pulse `err`, `entry` unchanged.
- Backspace: if `cnt`>0, `entry` shifted right 4 and `cnt`--; else no-op. Allowed in ENTER_A and ENTER_B.
- Esc: all registers return to their reset values.
- FSM:
  - ENTER_A, operator: `operand_a`<=`entry`, `opcode` set, `entry`/`cnt` cleared, go to ENTER_B. An operator with `cnt`=0 latches `operand_a`=0.
  - ENTER_A, Enter: ignored.
  - ENTER_B, operator: replaces `opcode` only if `cnt`=0; otherwise ignored.
  - ENTER_B, Enter: `operand_b`<=`entry`, `go`=1, `entry`/`cnt` cleared, go to DONE.
  - DONE, digit: `operand_a`/`operand_b` cleared, `entry`=d, `cnt`=1, go to ENTER_A.
  - DONE, operator/Enter/Backspace: ignored.
- Reset values: every output 0, `state`=ENTER_A, `brk`/`ext`/`held` cleared, `cnt`=0.
- Reset mid-sequence discards pending prefixes: a byte after reset is a fresh make.

## Timing
- Each byte is processed in its strobe cycle. All outputs are registered and change on the edge ending that cycle, giving 1-cycle latency.
- Back-to-back strobes are processed every cycle, with no gaps required.
- `go` and `err` are high for exactly one cycle, the cycle after the triggering strobe.
- `operand_b`, `opcode` and `operand_a` are stable in the `go` cycle and held until the next edit.
- `rst_n` low wins over a simultaneous `code_valid`.

## Test plan
- Sequence 16, F0 16, 1E, F0 1E, 79, F0 79, 25, F0 25, 5A, F0 5A → `operand_a`=0x0012, `opcode`=00, `operand_b`=0x0004.
  - `go` high exactly one cycle after the 5A strobe; `state`=10.
- Typematic 16, 16, 16, F0 16, 16 → `entry`=0x0011.
- Overflow with DIGITS=4, keys 1 2 3 4 5 (each with break) → `entry`=0x1234, `err` pulses once after the 5's make, `cnt`=4.
- Extended: 69, E0 4A, E0 70, 72, E0 5A, E0 F0 5A → `operand_a`=0x0001, `opcode`=11, `operand_b`=0x0002, `go` after the E0 5A, `state`=10.
  - E0 70 must not enter digit 0.
- Edits: 16, 1E, 66 → `entry`=0x0001. Then 79, 7B → `opcode`=01. Then 76 → all outputs 0, `state`=00.
- Reset: F0, `rst_n` low one cycle, then 16 → `entry`=0x0001. `code_valid` with `rst_n` low has no effect.
